// File: rtl/riscv_lsu_ram_master.sv
// Load/store initiator between the core memory stage and one data-RAM port.
// Splits word-crossing accesses into two RAM cycles and aligns/extends load data.
module riscv_lsu_ram_master #(
  parameter int WIDTH    = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [3:0]       ram_be,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  typedef enum logic {IDLE, SPLIT2} state_t;
  state_t state;

  logic [1:0]         off;
  logic [2:0]         nbytes;
  logic [3:0]         mask;
  logic               crossing, illegal, err_req, split_req, accept;
  logic [7:0]         be_wide;
  logic [2*WIDTH-1:0] wd_wide;
  logic [WIDTH-1:0]   word_addr;

  // Registered request: second-access fields plus what the response needs
  logic [WIDTH-1:0]   r_addr2, r_wdata2, hold;
  logic [3:0]         r_be2;
  logic               r_we, r_uns, r_load, r_split;
  logic [1:0]         r_off, r_size;

  assign off       = req_addr[1:0];
  assign word_addr = {req_addr[WIDTH-1:2], 2'b00};

  always_comb begin
    mask   = 4'b1111;
    nbytes = 3'd4;
    case (req_size)
      2'b00:   begin mask = 4'b0001; nbytes = 3'd1; end
      2'b01:   begin mask = 4'b0011; nbytes = 3'd2; end
      default: begin mask = 4'b1111; nbytes = 3'd4; end
    endcase
  end

  assign crossing  = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
  assign illegal   = (req_size == 2'b11);
  assign err_req   = illegal | (crossing & ~SPLIT_EN);
  assign split_req = crossing & SPLIT_EN & ~illegal;
  assign req_ready = ~rst & (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Low half of each wide value is the first access, high half the second
  assign be_wide = {4'b0000, mask} << off;
  assign wd_wide = {{WIDTH{1'b0}}, req_wdata} << {off, 3'b000};

  always_comb begin
    if (state == SPLIT2) begin
      ram_en    = ~rst;
      ram_we    = ~rst & r_we;
      ram_be    = r_be2;
      ram_addr  = r_addr2;
      ram_wdata = r_wdata2;
    end else begin
      ram_en    = accept & ~err_req;
      ram_we    = accept & ~err_req & req_we;
      ram_be    = be_wide[3:0];
      ram_addr  = word_addr;
      ram_wdata = wd_wide[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      hold      <= '0;
      r_addr2   <= '0;
      r_wdata2  <= '0;
      r_be2     <= '0;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_load    <= 1'b0;
      r_split   <= 1'b0;
      r_off     <= '0;
      r_size    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          r_addr2  <= word_addr + WIDTH'(4);
          r_wdata2 <= wd_wide[2*WIDTH-1:WIDTH];
          r_be2    <= be_wide[7:4];
          r_we     <= req_we;
          r_uns    <= req_unsigned;
          r_load   <= ~req_we & ~err_req;
          r_split  <= split_req;
          r_off    <= off;
          r_size   <= req_size;
          if (split_req) state <= SPLIT2;
          else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_req;
          end
        end
        SPLIT2: begin
          hold      <= ram_rdata;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load merge: the split case sees the second word on ram_rdata and the first in hold
  logic [2*WIDTH-1:0] merged, shifted;
  logic [WIDTH-1:0]   lo, ext;

  assign merged  = r_split ? {ram_rdata, hold} : {{WIDTH{1'b0}}, ram_rdata};
  assign shifted = merged >> {r_off, 3'b000};
  assign lo      = shifted[WIDTH-1:0];

  always_comb begin
    ext = lo;
    case (r_size)
      2'b00:   ext = {{(WIDTH-8){~r_uns & lo[7]}}, lo[7:0]};
      2'b01:   ext = {{(WIDTH-16){~r_uns & lo[15]}}, lo[15:0]};
      default: ext = lo;
    endcase
  end

  assign rsp_rdata = (rsp_valid & r_load) ? ext : '0;

endmodule

// File: tb/tb_riscv_lsu_ram_master.sv
// Directed bench: a 4-word byte-enabled RAM model (aliased by addr[3:2]) behind the
// split-enabled LSU, plus a SPLIT_EN=0 instance sharing the request inputs.
module tb_riscv_lsu_ram_master;

  logic        clk = 1'b0;
  logic        rst, load_mem;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, ram_en, ram_we;
  logic [31:0] rsp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;

  logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_ram_en, ns_ram_we;
  logic [31:0] ns_rsp_rdata, ns_ram_addr, ns_ram_wdata;
  logic [31:0] ns_ram_rdata = 32'h0;
  logic [3:0]  ns_ram_be;

  logic [31:0] mem [0:3];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  riscv_lsu_ram_master #(.WIDTH(32), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  riscv_lsu_ram_master #(.WIDTH(32), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ns_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(ns_rsp_valid),
    .rsp_err(ns_rsp_err), .rsp_rdata(ns_rsp_rdata), .ram_en(ns_ram_en), .ram_we(ns_ram_we),
    .ram_be(ns_ram_be), .ram_addr(ns_ram_addr), .ram_wdata(ns_ram_wdata), .ram_rdata(ns_ram_rdata)
  );

  always @(posedge clk) begin
    if (load_mem) begin
      mem[0] <= 32'h44332211;
      mem[1] <= 32'h88776655;
      mem[2] <= 32'h00000000;
      mem[3] <= 32'hDDCCBBAA;
    end else if (ram_en) begin
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[3:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr[3:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  // Non-split load: check first access at T and the response at T+1
  task automatic load1(input string tag, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp);
    @(negedge clk); req(1'b0, size, uns, addr, 32'h0); #1;
    chk({tag, "_en"}, ram_en, 1);
    chk({tag, "_addr"}, ram_addr, exp_addr);
    chk({tag, "_be"}, ram_be, exp_be);
    @(negedge clk); req_valid = 1'b0; #1;
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_data"}, rsp_rdata, exp);
  endtask

  // Split word load; the SPLIT_EN=0 instance must error on the same request
  task automatic split_ld(input string tag, input logic [31:0] addr, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] exp);
    @(negedge clk); req(1'b0, 2'b10, 1'b0, addr, 32'h0); #1;
    chk({tag, "_a1"}, ram_addr, a1);
    chk({tag, "_en1"}, ram_en, 1);
    chk({tag, "_ns_en"}, ns_ram_en, 0);
    @(negedge clk); req_valid = 1'b0; #1;
    chk({tag, "_a2"}, ram_addr, a2);
    chk({tag, "_en2"}, ram_en, 1);
    chk({tag, "_rdy"}, req_ready, 0);
    chk({tag, "_vld_early"}, rsp_valid, 0);
    chk({tag, "_ns_vld"}, ns_rsp_valid, 1);
    chk({tag, "_ns_err"}, ns_rsp_err, 1);
    chk({tag, "_ns_data"}, ns_rsp_rdata, 0);
    @(negedge clk); #1;
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_rdata, exp);
    chk({tag, "_rdy_back"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; load_mem = 1'b1;
    req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ns_ram_en", ns_ram_en, 0);
    @(negedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    load_mem = 1'b0; rst = 1'b0; req_valid = 1'b0;

    load1("lb3",   2'b00, 1'b0, 32'h3, 32'h0, 4'b1000, 32'h00000044);
    load1("lb7",   2'b00, 1'b0, 32'h7, 32'h4, 4'b1000, 32'hFFFFFF88);
    load1("lbu7",  2'b00, 1'b1, 32'h7, 32'h4, 4'b1000, 32'h00000088);
    load1("lh6",   2'b01, 1'b0, 32'h6, 32'h4, 4'b1100, 32'hFFFF8877);
    load1("lhu6",  2'b01, 1'b1, 32'h6, 32'h4, 4'b1100, 32'h00008877);

    split_ld("lw2",  32'h2,        32'h0,        32'h4, 32'h66554433);
    split_ld("lw1",  32'h1,        32'h0,        32'h4, 32'h55443322);
    split_ld("lwfe", 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0, 32'h2211DDCC);

    // Illegal size: no RAM access, error response with zero data
    @(negedge clk); req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0); #1;
    chk("ill_en", ram_en, 0);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("ill_vld", rsp_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_data", rsp_rdata, 0);

    // Back-to-back aligned words
    @(negedge clk); req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    @(negedge clk); req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0); #1;
    chk("b2b0_vld", rsp_valid, 1);
    chk("b2b0_data", rsp_rdata, 32'h44332211);
    chk("b2b_rdy", req_ready, 1);
    @(negedge clk); req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0); #1;
    chk("b2b1_vld", rsp_valid, 1);
    chk("b2b1_data", rsp_rdata, 32'h88776655);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("b2b2_vld", rsp_valid, 1);
    chk("b2b2_data", rsp_rdata, 32'h44332211);
    @(negedge clk); #1;
    chk("b2b_idle_vld", rsp_valid, 0);

    // Split SH @3
    @(negedge clk); req(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000BEEF); #1;
    chk("sh_we1", ram_we, 1);
    chk("sh_be1", ram_be, 4'b1000);
    chk("sh_wd1", ram_wdata, 32'hEF000000);
    chk("sh_a1", ram_addr, 32'h0);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("sh_we2", ram_we, 1);
    chk("sh_be2", ram_be, 4'b0001);
    chk("sh_wd2", ram_wdata, 32'h000000BE);
    chk("sh_a2", ram_addr, 32'h4);
    @(negedge clk); #1;
    chk("sh_vld", rsp_valid, 1);
    chk("sh_data", rsp_rdata, 0);
    chk("sh_mem0", mem[0], 32'hEF332211);
    chk("sh_mem1", mem[1], 32'h887766BE);

    // Reset during the second half of a split SW @1
    @(negedge clk); req(1'b1, 2'b10, 1'b0, 32'h1, 32'hCAFEF00D); #1;
    chk("swr_be1", ram_be, 4'b1110);
    @(negedge clk); req_valid = 1'b0; rst = 1'b1; #1;
    chk("swr_en2", ram_en, 0);
    chk("swr_rdy", req_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("swr_vld", rsp_valid, 0);
    chk("swr_rdy_after", req_ready, 1);
    chk("swr_mem0", mem[0], 32'hFEF00D11);
    chk("swr_mem1", mem[1], 32'h887766BE);
    @(negedge clk); #1;
    chk("swr_vld_after", rsp_valid, 0);
    chk("swr_en_idle", ram_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_lsu_ram_master.md
# riscv_lsu_ram_master

Load/store initiator that converts RISC-V core data-memory requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-addressed, byte-enabled accesses on one port of the dual-port data RAM. It sits between the core's memory stage and the RAM's read/write port. It splits accesses that cross a word boundary into two RAM cycles, aligns store data, and merges, aligns and sign-/zero-extends load data. Its RAM side matches the RAM port protocol: 1-cycle read latency, byte-lane write enables, byte address with the low 2 bits ignored.

## Interface
- WIDTH, 32, data/address width; only 32 is supported.
- SPLIT_EN, 1, 1 splits misaligned accesses into two RAM cycles; 0 answers them with `rsp_err` and no RAM access.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  request accepted when `req_valid && req_ready`.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for words and stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse for each accepted request; no backpressure.
- rsp_err  out  1  illegal size, or misaligned access with SPLIT_EN=0; qualified by `rsp_valid`.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- ram_en, ram_we  out  1  RAM port enable and write strobe.
- ram_be  out  4  byte-lane write enables.
- ram_addr  out  32  byte address with [1:0] = 0.
- ram_wdata  out  32  lane-aligned store data.
- ram_rdata  in  32  RAM read data, valid the cycle after `ram_en`.

## Operation
- States: IDLE, SPLIT2.
- `req_ready` = (state == IDLE).
- Offset o = `req_addr[1:0]`; n = 1/2/4 bytes. Crossing = o + n > 4.
- First access is combinational from the request in the accept cycle:
  - `ram_addr` = {addr[31:2], 2'b00}
  - `ram_be` = (((1<<n)-1) << o) & 4'hF
  - `ram_wdata` = `req_wdata` << 8o
  - `ram_we` = `req_we`
- Crossing with SPLIT_EN=1: register the request, go to SPLIT2. In SPLIT2 issue the second access, then return to IDLE:
  - address = first word address + 4; wraps 0xFFFF_FFFC → 0x0000_0000
  - be = ((1<<n)-1) >> (4-o)
  - wdata = `req_wdata` >> 8(4-o)
  - capture `ram_rdata` (first word) into a hold register in this cycle
- Load merge:
  - aligned: ({32'b0, word} >> 8o)[31:0]
  - split: ({second, first} >> 8o)[31:0]
  - then sign-extend bit 8n-1 unless `req_unsigned`, or zero-extend if set.
- Stores drive the same lanes; `ram_be` is all-ones-masked per lanes for loads too; the RAM ignores it on reads.
- Illegal size, or crossing with SPLIT_EN=0: no `ram_en`; `rsp_err` = 1 with the response.
- No address range check; the RAM aliases out-of-range addresses.

## Timing
- Accept in cycle T.
- Non-split: RAM access at T; `rsp_valid` at T+1. Load `rsp_rdata` at T+1 is computed combinationally from `ram_rdata` and registered offset/size/unsigned.
- Split: accesses at T and T+1; `req_ready` = 0 at T+1; `rsp_valid` at T+2.
- Throughput:
  - Non-split requests may be accepted every cycle (response at T+1 overlaps the next accept).
  - After a split, the next request may be accepted at T+2.
- `rsp_valid`, `rsp_err` and state are registered.
- Reset values: state IDLE, `rsp_valid` = 0, `rsp_err` = 0, hold register 0. While `rst` = 1: `req_ready` = 0 and `ram_en` = 0.
- Reset during SPLIT2: the second access is not issued and no response is produced. A first-half store already written stays written.
- `ram_en` is never asserted in a cycle without an accepted request, except in SPLIT2.

## Test plan
Preload mem[0] = 0x44332211, mem[1] = 0x88776655.
- LB @3 → `rsp_rdata` 0x00000044 at T+1. LB @7 → 0xFFFFFF88. LBU @7 → 0x00000088. LH @6 → 0xFFFF8877.
- LW @2 (split) → `ram_addr` 0x0 at T, 0x4 at T+1, `req_ready` low at T+1; `rsp_rdata` 0x66554433 at T+2.
- SH @3, wdata 0x0000BEEF → T: be 1000, wdata 0xEF000000, addr 0x0; T+1: be 0001, wdata 0x000000BE, addr 0x4. Afterwards mem[0] = 0xEF332211, mem[1] = 0x887766BE.
- size = 11, and LW @1 with SPLIT_EN=0 → `ram_en` stays 0; `rsp_valid` and `rsp_err` = 1 at T+1; `rsp_rdata` = 0.
- Back-to-back LW @0, @4, @0 on consecutive cycles → three responses on consecutive cycles: 0x44332211, 0x88776655, 0x44332211.
- LW @0xFFFFFFFE → second access at 0x00000000. Separately, assert `rst` at T+1 of a split SW → no second `ram_en`, no `rsp_valid`; `req_ready` = 1 the cycle after `rst` drops.
